// File: rtl/vliw_fwd_pkg.sv
// Shared types and select encodings for the VLIW forwarding / hazard unit.
// Shadow slots store destination addresses at a fixed maximum width so the struct needs no parameters.
package vliw_fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_LDWB  = 2'b11;

    // Upper bound on the register address width a slot can carry.
    localparam int MAX_REG_AW = 8;

    typedef struct packed {
        logic                  aluWe;
        logic [MAX_REG_AW-1:0] aluRd;
        logic                  ldWe;
        logic [MAX_REG_AW-1:0] ldRd;
    } shadow_slot_t;

endpackage

// File: rtl/fwd_operand_match.sv
// Priority compare of one source operand against the in-flight producers.
// Younger slots win; inside a slot the load lane wins over the ALU lane.
module fwd_operand_match
    import vliw_fwd_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] src,
    input  shadow_slot_t      exSlot,
    input  shadow_slot_t      memSlot,
    input  shadow_slot_t      wbSlot,
    output logic [1:0]        sel,
    output logic              hazard
);

    logic [MAX_REG_AW-1:0] srcExt;

    assign srcExt = MAX_REG_AW'(src);

    always_comb begin
        sel    = FWD_RF;
        hazard = 1'b0;
        if (src != '0) begin
            if (exSlot.ldWe && exSlot.ldRd == srcExt) begin
                hazard = 1'b1;
            end else if (exSlot.aluWe && exSlot.aluRd == srcExt) begin
                sel = FWD_EXMEM;
            end else if (memSlot.ldWe && memSlot.ldRd == srcExt) begin
                sel = FWD_LDWB;
            end else if (memSlot.aluWe && memSlot.aluRd == srcExt) begin
                sel = FWD_MEMWB;
            end else if ((wbSlot.ldWe && wbSlot.ldRd == srcExt) ||
                         (wbSlot.aluWe && wbSlot.aluRd == srcExt)) begin
                // Register file writes before it reads, so a WB producer needs no bypass.
                sel = FWD_RF;
            end
        end
    end

endmodule

// File: rtl/vliw_fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit beside the ID/EX register.
// Keeps a shadow EX/MEM/WB pipeline of destinations and a saturating stall counter.
module vliw_fwd_hazard_unit
    import vliw_fwd_pkg::*;
#(
    parameter int REG_AW  = 3,
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic                      id_alu_we,
    input  logic [REG_AW-1:0]         id_alu_rd,
    input  logic                      id_ld_we,
    input  logic [REG_AW-1:0]         id_ld_rd,
    input  logic                      pipe_hold,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);

    shadow_slot_t exSlot, memSlot, wbSlot;
    shadow_slot_t idSlot;
    logic [NUM_SRC*2-1:0] selNext;
    logic [NUM_SRC-1:0]   hazardVec;
    logic                 accept;

    assign idSlot = '{aluWe: id_alu_we, aluRd: MAX_REG_AW'(id_alu_rd),
                      ldWe:  id_ld_we,  ldRd:  MAX_REG_AW'(id_ld_rd)};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        fwd_operand_match #(.REG_AW(REG_AW)) u_match (
            .src     (id_src[i*REG_AW +: REG_AW]),
            .exSlot  (exSlot),
            .memSlot (memSlot),
            .wbSlot  (wbSlot),
            .sel     (selNext[i*2 +: 2]),
            .hazard  (hazardVec[i])
        );
    end

    // Handshake: stall is the inverse of ready. An ID bundle is consumed on a posedge
    // where id_valid && !stall && !flush && !pipe_hold; otherwise EX receives a bubble.
    assign stall  = !rst && id_valid && !flush && (|hazardVec);
    assign accept = id_valid && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            exSlot    <= '0;
            memSlot   <= '0;
            wbSlot    <= '0;
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else if (!pipe_hold) begin
            wbSlot  <= memSlot;
            memSlot <= exSlot;
            exSlot  <= accept ? idSlot : '0;
            fwd_sel <= accept ? selNext : '0;
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vliw_fwd_hazard_unit.sv
// Directed bench for vliw_fwd_hazard_unit with hand-computed selects and stall counts.
// Counter width is reduced so saturation is reachable in a short run.
module tb_vliw_fwd_hazard_unit;

    localparam int REG_AW  = 3;
    localparam int NUM_SRC = 4;
    localparam int CNT_W   = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic                      id_alu_we;
    logic [REG_AW-1:0]         id_alu_rd;
    logic                      id_ld_we;
    logic [REG_AW-1:0]         id_ld_rd;
    logic                      pipe_hold;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [CNT_W-1:0]          stall_cnt;

    int nChecks = 0;
    int nFails  = 0;
    int expCnt  = 0;
    int nStall  = 0;
    logic [NUM_SRC*2-1:0] expQ[$];

    vliw_fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_src    (id_src),
        .id_alu_we (id_alu_we),
        .id_alu_rd (id_alu_rd),
        .id_ld_we  (id_ld_we),
        .id_ld_rd  (id_ld_rd),
        .pipe_hold (pipe_hold),
        .flush     (flush),
        .stall     (stall),
        .fwd_sel   (fwd_sel),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        id_valid  = 1'b0;
        id_src    = '0;
        id_alu_we = 1'b0;
        id_alu_rd = '0;
        id_ld_we  = 1'b0;
        id_ld_rd  = '0;
    endtask

    task automatic setBundle(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                             input logic [2:0] s3, input logic aw, input logic [2:0] ard,
                             input logic lw, input logic [2:0] lrd);
        id_valid  = 1'b1;
        id_src    = {s3, s2, s1, s0};
        id_alu_we = aw;
        id_alu_rd = ard;
        id_ld_we  = lw;
        id_ld_rd  = lrd;
    endtask

    task automatic checkStall(input string tag, input logic exp);
        @(negedge clk);
        check(tag, 32'(stall), 32'(exp));
    endtask

    task automatic checkSel(input string tag);
        logic [NUM_SRC*2-1:0] exp;
        exp = expQ.pop_front();
        check(tag, 32'(fwd_sel), 32'(exp));
    endtask

    task automatic drain();
        setIdle();
        repeat ($urandom_range(3, 5)) tick();
    endtask

    initial begin
        rst = 1'b1;
        pipe_hold = 1'b0;
        flush = 1'b0;
        setIdle();
        tick();
        tick();
        checkStall("reset_stall", 1'b0);
        check("reset_sel", 32'(fwd_sel), 32'h0);
        check("reset_cnt", 32'(stall_cnt), 32'h0);
        rst = 1'b0;
        tick();

        // ALU result forwarded back-to-back
        setBundle(0, 0, 0, 0, 1, 3, 0, 0);
        checkStall("alu_a_stall", 1'b0);
        tick();
        setBundle(3, 0, 0, 0, 0, 0, 0, 0);
        checkStall("alu_b_stall", 1'b0);
        tick();
        expQ.push_back(8'h01);
        checkSel("alu_b2b_sel");
        drain();

        // Load-use: one bubble, then load result from MEM/WB
        setBundle(0, 0, 0, 0, 0, 0, 1, 5);
        tick();
        setBundle(0, 0, 5, 0, 0, 0, 0, 0);
        checkStall("lu_stall", 1'b1);
        tick();
        expCnt = 1;
        check("lu_cnt", 32'(stall_cnt), 32'(expCnt));
        expQ.push_back(8'h00);
        checkSel("lu_bubble_sel");
        checkStall("lu_release", 1'b0);
        tick();
        expQ.push_back(8'h30);
        checkSel("lu_sel");
        drain();

        // Distance-2 ALU; lanes claiming r0 never forward or stall
        setBundle(0, 0, 0, 0, 1, 2, 0, 0);
        tick();
        setBundle(0, 0, 0, 0, 1, 0, 1, 0);
        tick();
        setBundle(1, 2, 0, 0, 0, 0, 0, 0);
        checkStall("d2_stall", 1'b0);
        tick();
        expQ.push_back(8'h08);
        checkSel("d2_sel");
        drain();

        // Youngest producer wins, then load lane beats ALU lane in one slot
        setBundle(0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        setBundle(0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        setBundle(4, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expQ.push_back(8'h01);
        checkSel("young_sel");
        drain();
        setBundle(0, 0, 0, 0, 1, 6, 1, 6);
        tick();
        setBundle(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        setBundle(6, 0, 0, 0, 0, 0, 0, 0);
        checkStall("lane_stall", 1'b0);
        tick();
        expQ.push_back(8'h03);
        checkSel("lane_sel");
        drain();

        // pipe_hold during a load-use stall freezes everything
        setBundle(0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        setBundle(1, 0, 0, 0, 0, 0, 1, 5);
        tick();
        expQ.push_back(8'h01);
        checkSel("hold_pre_sel");
        setBundle(0, 0, 5, 0, 0, 0, 0, 0);
        pipe_hold = 1'b1;
        repeat (3) begin
            checkStall("hold_stall", 1'b1);
            tick();
            check("hold_sel", 32'(fwd_sel), 32'h01);
            check("hold_cnt", 32'(stall_cnt), 32'(expCnt));
        end
        pipe_hold = 1'b0;
        checkStall("hold_rel_stall", 1'b1);
        tick();
        expCnt++;
        check("hold_rel_cnt", 32'(stall_cnt), 32'(expCnt));
        check("hold_rel_sel", 32'(fwd_sel), 32'h00);
        checkStall("hold_done_stall", 1'b0);
        tick();
        check("hold_done_sel", 32'(fwd_sel), 32'h30);
        check("hold_done_cnt", 32'(stall_cnt), 32'(expCnt));
        drain();

        // flush beats stall and squashes the ID bundle
        setBundle(0, 0, 0, 0, 0, 0, 1, 5);
        tick();
        setBundle(0, 0, 5, 0, 0, 0, 0, 0);
        flush = 1'b1;
        checkStall("flush_stall", 1'b0);
        tick();
        flush = 1'b0;
        check("flush_sel", 32'(fwd_sel), 32'h00);
        check("flush_cnt", 32'(stall_cnt), 32'(expCnt));
        checkStall("flush_after_stall", 1'b0);
        tick();
        check("flush_after_sel", 32'(fwd_sel), 32'h30);
        drain();
        setBundle(0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        setBundle(3, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_alu_sel", 32'(fwd_sel), 32'h00);
        drain();

        // Reset in the middle of a stall
        setBundle(0, 0, 0, 0, 1, 1, 1, 5);
        tick();
        setBundle(0, 1, 5, 0, 0, 0, 0, 0);
        checkStall("rst_pre_stall", 1'b1);
        rst = 1'b1;
        #1;
        check("rst_during_stall", 32'(stall), 32'h0);
        tick();
        rst = 1'b0;
        expCnt = 0;
        check("rst_sel", 32'(fwd_sel), 32'h00);
        check("rst_cnt", 32'(stall_cnt), 32'(expCnt));
        checkStall("rst_post_stall", 1'b0);
        tick();
        drain();

        // A bundle that reads and loads r5 stalls every other cycle: drive counter to saturation
        setBundle(5, 0, 0, 0, 0, 0, 1, 5);
        nStall = 0;
        repeat (2 * ((1 << CNT_W) + 5)) begin
            @(negedge clk);
            if (stall) nStall++;
            tick();
        end
        check("sat_stalls_seen", 32'(nStall >= (1 << CNT_W) + 5), 32'h1);
        check("sat_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
        setIdle();
        tick();
        check("sat_hold_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/vliw_fwd_hazard_unit.md
Name: vliw_fwd_hazard_unit

Overview:
- Parametrised successor to the combinational 4-operand forwarding unit in the VLIW datapath.
- Tracks in-flight destination registers internally as a shadow pipeline (EX, MEM, WB slots) for two write lanes: ALU and load.
- Produces registered per-operand forwarding selects aligned to the EX stage.
- Detects load-use hazards and raises a stall that inserts a bubble.
- Sits beside the ID/EX pipeline register and keeps a saturating stall counter.

Parameters:
- REG_AW, 3: register address width; address 0 is hardwired zero and never forwarded.
- NUM_SRC, 4: number of source operands checked per bundle.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  bundle present in ID
- id_src  in  NUM_SRC*REG_AW  source register addresses of ID bundle; operand i at [i*REG_AW +: REG_AW]
- id_alu_we  in  1  bundle's ALU lane writes a register
- id_alu_rd  in  REG_AW  ALU lane destination
- id_ld_we  in  1  bundle's load lane writes a register
- id_ld_rd  in  REG_AW  load lane destination
- pipe_hold  in  1  global freeze (memory wait)
- flush  in  1  squash bundle in ID and EX (branch taken)
- stall  out  1  hold PC and IF/ID; combinational
- fwd_sel  out  NUM_SRC*2  per-operand select, registered, valid while bundle is in EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=1 at posedge):
  - All shadow slots invalid.
  - fwd_sel = 0, stall_cnt = 0.
  - stall is 0 during and after reset until a valid hazard appears.
- Select encoding:
  - 00 = register file. The file is write-before-read, so a WB-slot match also gives 00.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB ALU result.
  - 11 = MEM/WB load result.
- Shadow slots: ex, mem, wb. Each holds {alu_we, alu_rd, ld_we, ld_rd}.
- Advance (posedge, pipe_hold=0):
  - wb<=mem and mem<=ex.
  - ex<=ID bundle if id_valid && !stall && !flush; otherwise ex<=bubble (all we=0).
- pipe_hold=1: all slots, fwd_sel and stall_cnt hold. stall is still computed but has no effect.
- Per-operand match (src != 0), evaluated for the ID bundle against where producers will be when that bundle reaches EX:
  - ex.ld_we && ex.ld_rd==src: load-use hazard, so stall=1.
  - else ex.alu_we && ex.alu_rd==src: sel 01.
  - else mem.ld_we && mem.ld_rd==src: sel 11.
  - else mem.alu_we && mem.alu_rd==src: sel 10.
  - else: sel 00.
  - Youngest producer wins.
  - Within a slot, the load lane beats the ALU lane when both write the same rd.
- stall = id_valid && !flush && (any operand hits a load-use hazard).
- fwd_sel update (posedge, !pipe_hold): loads the computed selects when the ID bundle is accepted; otherwise loads 0.
- Latency:
  - Selects appear one cycle after acceptance.
  - A load-use stall lasts exactly 1 cycle. After the bubble the load sits in mem, so sel 11 resolves.
- flush has priority over stall: stall=0, and ex receives a bubble.
- rst has priority over pipe_hold and flush. rst mid-stall clears everything; no stall is pending after reset.
- stall_cnt increments on each posedge with stall && !pipe_hold. It saturates at all-ones with no wrap.
- Source address 0 never matches, even if a lane claims to write r0.

Decomposition:
- Package vliw_fwd_pkg: FWD_RF/FWD_EXMEM/FWD_MEMWB/FWD_LDWB constants and the shadow-slot struct typedef.
- One sub-module, fwd_operand_match: one operand's priority compare. Outputs sel[1:0] and hazard. Instantiated NUM_SRC times via generate.
- Shadow pipeline, stall logic and counter stay in the top.

Test Plan:
- ALU back-to-back: bundle A alu r3; next bundle src0=r3 -> stall=0; fwd_sel[1:0]=01 one cycle after acceptance.
- Load-use: load r5; next bundle src2=r5 -> stall=1 for 1 cycle, stall_cnt=1; then accepted with fwd_sel[5:4]=11.
- Distance-2 ALU plus r0: alu r2, unrelated bundle, then src1=r2 and src3=r0 -> fwd_sel[3:2]=10, fwd_sel[7:6]=00.
- Same-rd priority: alu r4 in mem slot, alu r4 in ex slot, consumer src0=r4 -> 01. Then a bundle with both lanes writing r6, consumer two cycles later -> 11.
- pipe_hold during a load-use stall for 3 cycles -> slots, fwd_sel and stall_cnt frozen. After release the stall completes once and stall_cnt increments by exactly 1.
- Flush and reset:
  - flush asserted with a load-use consumer in ID -> stall=0, bubble, fwd_sel=0.
  - rst mid-stall -> all outputs 0 the next cycle.
  - Force stall for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones.
